// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite data-memory responder.
package axil_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/dp_word_ram.sv
// Word-organised RAM: one byte-enabled write port, one synchronous read port.
// A same-address read and write in one cycle returns the old word.
module dp_word_ram
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [STRB_W-1:0] wbe_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Read samples the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_dmem_responder.sv
// AXI4-Lite responder in front of the CPU data RAM; independent read and write
// channels, one outstanding transaction each.
// Optional feature: define AXIL_DMEM_WSTRB_EN to honour wstrb byte enables;
// otherwise every in-range write updates the full word.
module axil_dmem_responder
    import axil_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int unsigned     IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

    // In-window test done with a borrow bit so no comparison folds to a constant.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[ADDR_W] && ({1'b0, diff[ADDR_W-1:0]} < WIN_BYTES);
    endfunction

    // Word index of a byte address; the two byte-lane bits are dropped.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel ----------------
    wr_state_t         wr_q;
    logic              aw_held_q, w_held_q;
    logic              awready_q, wready_q, bvalid_q;
    axi_resp_t         bresp_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              aw_hs, w_hs, aw_held_d, w_held_d, commit_c, w_hit_c;
    logic [ADDR_W-1:0] waddr_eff;
    logic [DATA_W-1:0] wdata_eff;
    logic [STRB_W-1:0] wbe_c;

    assign aw_hs     = awvalid & awready_q;
    assign w_hs      = wvalid & wready_q;
    assign aw_held_d = aw_held_q | aw_hs;
    assign w_held_d  = w_held_q | w_hs;
    assign waddr_eff = aw_held_q ? awaddr_q : awaddr;
    assign wdata_eff = w_held_q ? wdata_q : wdata;
    assign commit_c  = (wr_q == W_IDLE) & aw_held_d & w_held_d;
    assign w_hit_c   = addr_hit(waddr_eff);

`ifdef AXIL_DMEM_WSTRB_EN
    logic [STRB_W-1:0] wstrb_q;
    assign wbe_c = w_held_q ? wstrb_q : wstrb;

    // Strobes travel with the W beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstrb_q <= '0;
        end else if (w_hs) begin
            wstrb_q <= wstrb;
        end
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign wbe_c        = '1;
`endif

    // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs)  wdata_q  <= wdata;
            case (wr_q)
                W_IDLE: begin
                    if (commit_c) begin
                        wr_q      <= W_RESP;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_hit_c ? OKAY : SLVERR;
                    end else begin
                        aw_held_q <= aw_held_d;
                        w_held_q  <= w_held_d;
                        awready_q <= !aw_held_d;
                        wready_q  <= !w_held_d;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_q      <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    // ---------------- read channel ----------------
    rd_state_t         rd_q;
    logic              arready_q, rvalid_q;
    axi_resp_t         rresp_q;
    logic              ar_hs, r_hit_c;
    logic [DATA_W-1:0] ram_rdata;

    assign ar_hs   = arvalid & arready_q;
    assign r_hit_c = addr_hit(araddr);

    // Read FSM: accept AR, RAM returns the word on the next edge, hold R until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
        end else begin
            case (rd_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_q      <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= r_hit_c ? OKAY : SLVERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_q      <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    // Error and idle responses carry zero data.
    assign rdata   = (rvalid_q && rresp_q == OKAY) ? ram_rdata : '0;

    dp_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (commit_c & w_hit_c),
        .waddr_i (addr_idx(waddr_eff)),
        .wbe_i   (wbe_c),
        .wdata_i (wdata_eff),
        .re_i    (ar_hs & r_hit_c),
        .raddr_i (addr_idx(araddr)),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axil_dmem_responder.sv
// Scoreboard bench for axil_dmem_responder: stimulus pushes expected B/R
// responses, a negedge monitor pops and compares on each handshake.
module tb_axil_dmem_responder;
    import axil_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4096;

`ifdef AXIL_DMEM_WSTRB_EN
    localparam logic [31:0] EXP_STRB = 32'hAA22CC44;
    localparam logic [31:0] EXP_ZERO = 32'hAA22CC44;
`else
    localparam logic [31:0] EXP_STRB = 32'h11223344;
    localparam logic [31:0] EXP_ZERO = 32'h55555555;
`endif

    logic        clk, rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_dmem_responder #(
        .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: a valid&ready seen at negedge completes on the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bvalid && bready) begin
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    e = bq.pop_front();
                    check("bresp", 64'(bresp), 64'(e.resp));
                end
            end
            if (!rst && rvalid && rready) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    e = rq.pop_front();
                    check("rresp_rdata", 64'({rresp, rdata}), 64'({e.resp, e.data}));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive the requested channels together and hold until all handshake on one edge.
    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] ra);
        bit ok;
        awvalid = do_aw; awaddr = wa;
        wvalid  = do_w;  wdata  = wd; wstrb = ws;
        arvalid = do_ar; araddr = ra;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((!do_aw || awready) && (!do_w || wready) && (!do_ar || arready)) ok = 1'b1;
        end
        if (!ok) fail_now("issue_timeout");
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    endtask

    task automatic wait_idle;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid) ok = 1'b1;
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        bq.push_back('{resp: resp, data: 32'h0});
        issue(1'b1, 1'b1, 1'b0, a, d, s, 32'h0);
        check("bvalid_latency", 64'(bvalid), 64'd1);
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        rq.push_back('{resp: resp, data: d});
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, a);
        check("rvalid_latency", 64'(rvalid), 64'd1);
        wait_idle();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata});
    endfunction

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = 4'hF; wvalid = 0;
        araddr = '0; arvalid = 0; bready = 1; rready = 1;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        check("ready_before_edge", 64'({awready, wready, arready}), 64'd0);
        tick();
        check("ready_after_release", 64'({awready, wready, arready}), 64'h7);

        // 1: reset during a half-captured write
        do_write(32'h40, 32'hCAFEF00D, 4'hF, RESP_OKAY);
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0);
        check("aw_captured_drop", 64'({awready, wready}), 64'h1);
        rst = 1'b1;
        #2;
        check("reset_mid_outputs", all_outs(), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("ready_after_mid_reset", 64'({awready, wready, arready}), 64'h7);
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("no_b_without_aw", 64'(bvalid), 64'd0);
            tick();
        end
        bq.push_back('{resp: RESP_OKAY, data: 32'h0});
        issue(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'hF, 32'h0);
        wait_idle();
        do_read(32'h40, 32'hCAFEF00D, RESP_OKAY);
        do_read(32'h44, 32'hFFFFFFFF, RESP_OKAY);

        // 2: AW two cycles ahead of W
        bq.push_back('{resp: RESP_OKAY, data: 32'h0});
        issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0);
        check("aw_first_ready", 64'({awready, wready}), 64'h1);
        tick();
        check("no_b_before_w", 64'(bvalid), 64'd0);
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0);
        check("b_after_w", 64'(bvalid), 64'd1);
        wait_idle();
        do_read(32'h10, 32'hDEADBEEF, RESP_OKAY);

        // 3: same-cycle AW+W with B back-pressure
        bready = 1'b0;
        bq.push_back('{resp: RESP_OKAY, data: 32'h0});
        issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h5A5A0020, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("b_held", 64'({bvalid, bresp, awready, wready}), 64'h10);
            tick();
        end
        bready = 1'b1;
        wait_idle();
        do_read(32'h20, 32'h5A5A0020, RESP_OKAY);

        // 4: window boundaries
        do_write(32'h0, 32'h01234567, 4'hF, RESP_OKAY);
        do_read(32'h4000, 32'h0, RESP_SLVERR);
        do_write(32'h4000, 32'hFFFFFFFF, 4'hF, RESP_SLVERR);
        do_read(32'h0, 32'h01234567, RESP_OKAY);
        do_write(32'h3FFC, 32'h13579BDF, 4'hF, RESP_OKAY);
        do_read(32'h3FFF, 32'h13579BDF, RESP_OKAY);
        do_read(32'hFFFFFFFC, 32'h0, RESP_SLVERR);

        // 5: write commit and read of the same word on one edge
        do_write(32'h30, 32'h11111111, 4'hF, RESP_OKAY);
        issue(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 32'h0);
        bq.push_back('{resp: RESP_OKAY, data: 32'h0});
        rq.push_back('{resp: RESP_OKAY, data: 32'h11111111});
        issue(1'b0, 1'b1, 1'b1, 32'h0, 32'h22222222, 4'hF, 32'h30);
        check("collision_both_valid", 64'({bvalid, rvalid}), 64'h3);
        wait_idle();
        do_read(32'h30, 32'h22222222, RESP_OKAY);

        // 6: byte strobes
        do_write(32'h50, 32'hAABBCCDD, 4'hF, RESP_OKAY);
        do_write(32'h50, 32'h11223344, 4'b0101, RESP_OKAY);
        do_read(32'h50, EXP_STRB, RESP_OKAY);
        do_write(32'h50, 32'h55555555, 4'b0000, RESP_OKAY);
        do_read(32'h50, EXP_ZERO, RESP_OKAY);

        check("bq_drained", 64'(bq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
